// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns: one 128-bit state register transformed in place, COLS_PER_CYCLE columns per clock.
// Optional macro MIX_COLUMNS_ITER_INV_EN adds an `inv` input selecting InvMixColumns.
module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data
`ifdef MIX_COLUMNS_ITER_INV_EN
  ,
  input  logic         inv
`endif
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // col_idx wraps to 0 when all four columns go in one cycle
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE % 4);
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [0:127] st_reg;
  logic [0:127] st_next;
  logic [1:0]   col_idx;
  logic         accept;
`ifdef MIX_COLUMNS_ITER_INV_EN
  logic         inv_reg;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row 0 sits in the upper byte of the packed column
  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0] s [4];
    logic [7:0] m2 [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      s[i]  = c[31-8*i -: 8];
      m2[i] = xtime(s[i]);
    end
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[31-8*i -: 8] = m2[i] ^ m2[(i+1)%4] ^ s[(i+1)%4] ^ s[(i+2)%4] ^ s[(i+3)%4];
    end
    return r;
  endfunction

`ifdef MIX_COLUMNS_ITER_INV_EN
  function automatic logic [31:0] mix_inv(input logic [31:0] c);
    logic [7:0] s [4];
    logic [7:0] x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      s[i]  = c[31-8*i -: 8];
      x2    = xtime(s[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ s[i];
      mb[i] = x8 ^ x2 ^ s[i];
      md[i] = x8 ^ x4 ^ s[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
    end
    return r;
  endfunction
`endif

  always_comb begin
    logic [1:0]  idx;
    logic [31:0] col_in;
    st_next = st_reg;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      idx    = col_idx + 2'(j);
      col_in = st_reg[32*idx +: 32];
`ifdef MIX_COLUMNS_ITER_INV_EN
      st_next[32*idx +: 32] = inv_reg ? mix_inv(col_in) : mix_fwd(col_in);
`else
      st_next[32*idx +: 32] = mix_fwd(col_in);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = BUSY;
      BUSY: if (col_idx == LAST_COL) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // DONE releases in_ready with out_ready so accept and output handshake share an edge
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign out_data = st_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_reg  <= '0;
      col_idx <= '0;
`ifdef MIX_COLUMNS_ITER_INV_EN
      inv_reg <= 1'b0;
`endif
    end else if (accept) begin
      st_reg  <= in_data;
      col_idx <= '0;
`ifdef MIX_COLUMNS_ITER_INV_EN
      inv_reg <= inv;
`endif
    end else if (state == BUSY) begin
      st_reg  <= st_next;
      col_idx <= col_idx + COL_STEP;
    end
  end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter: three instances (1, 2, 4 columns per cycle) checked against a GF(2^8) matrix model.
module tb_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         iv   [3];
  logic         ir   [3];
  logic [0:127] id   [3];
  logic         ov   [3];
  logic         ordy [3];
  logic [0:127] od   [3];
`ifdef MIX_COLUMNS_ITER_INV_EN
  logic         inv_s [3];
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_columns_iter #(.COLS_PER_CYCLE(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .in_data   (id[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .out_data  (od[g])
`ifdef MIX_COLUMNS_ITER_INV_EN
      ,
      .inv       (inv_s[g])
`endif
    );
  end

  typedef struct {
    string        nm;
    logic [0:127] din;
    bit           inv_b;
    logic [0:127] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic int cpc_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // Circulant matrix product per column; coefficient row r is base rotated right by r
  function automatic logic [0:127] mix_ref(input logic [0:127] s, input bit inv_b);
    logic [7:0]   base [4];
    logic [0:127] r = '0;
    logic [7:0]   acc;
    if (inv_b) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else       base = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc ^= gmul(base[(j - row + 4) % 4], s[8*(4*c+j) +: 8]);
        r[8*(4*c+row) +: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic accept_one(input int k, input logic [0:127] din, input bit inv_b);
    @(negedge clk);
    iv[k] = 1'b1;
    id[k] = din;
`ifdef MIX_COLUMNS_ITER_INV_EN
    inv_s[k] = inv_b;
`endif
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
    id[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
`ifdef MIX_COLUMNS_ITER_INV_EN
    inv_s[k] = ~inv_b;
`else
    if (inv_b) $display("note: inverse request ignored in forward-only build");
`endif
  endtask

  task automatic wait_out(input int k, output int cyc);
    cyc = 0;
    while (!ov[k] && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_vec(input int k, input string nm, input logic [0:127] din,
                         input bit inv_b, input logic [0:127] exp);
    int cyc;
    accept_one(k, din, inv_b);
    wait_out(k, cyc);
    chk($sformatf("k%0d %s latency", k, nm), cyc, 4 / cpc_of(k));
    chk($sformatf("k%0d %s data", k, nm), od[k], exp);
    @(posedge clk);
    #1;
    chk($sformatf("k%0d %s valid_drop", k, nm), ov[k], 0);
  endtask

  task automatic backpressure(input int k);
    logic [0:127] a, b, c;
    int cyc;
    a = {$urandom(), $urandom(), $urandom(), $urandom()};
    b = {$urandom(), $urandom(), $urandom(), $urandom()};
    c = {$urandom(), $urandom(), $urandom(), $urandom()};
    ordy[k] = 1'b0;
    accept_one(k, a, 1'b0);
    wait_out(k, cyc);
    chk($sformatf("k%0d bp latency", k), cyc, 4 / cpc_of(k));
    iv[k] = 1'b1;
    id[k] = b;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("k%0d bp hold data c%0d", k, i), od[k], mix_ref(a, 1'b0));
      chk($sformatf("k%0d bp in_ready c%0d", k, i), ir[k], 0);
      chk($sformatf("k%0d bp out_valid c%0d", k, i), ov[k], 1);
    end
    ordy[k] = 1'b1;
    #1;
    chk($sformatf("k%0d bp in_ready follows out_ready", k), ir[k], 1);
    @(posedge clk);
    #1;
    chk($sformatf("k%0d bp busy after swap", k), ov[k], 0);
    id[k] = c;
    wait_out(k, cyc);
    chk($sformatf("k%0d b2b latency B", k), cyc, 4 / cpc_of(k));
    chk($sformatf("k%0d b2b data B", k), od[k], mix_ref(b, 1'b0));
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
    id[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
    wait_out(k, cyc);
    chk($sformatf("k%0d b2b latency C", k), cyc, 4 / cpc_of(k));
    chk($sformatf("k%0d b2b data C", k), od[k], mix_ref(c, 1'b0));
    @(posedge clk);
    #1;
    chk($sformatf("k%0d b2b drained", k), ov[k], 0);
  endtask

  task automatic reset_mid_busy(input int k);
    bit seen;
    accept_one(k, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0);
    repeat (2 / cpc_of(k)) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk($sformatf("k%0d rst out_valid", k), ov[k], 0);
    chk($sformatf("k%0d rst out_data", k), od[k], 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk($sformatf("k%0d rst in_ready", k), ir[k], 1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (ov[k]) seen = 1'b1;
    end
    chk($sformatf("k%0d rst no stale result", k), seen, 0);
    run_vec(k, "fips_after_rst", 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0,
            128'h046681e5e0cb199a48f8d37a2806264c);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [0:127] r;
    bit rinv;

    tbl.push_back('{nm: "fips", din: 128'hd4bf5d30e0b452aeb84111f11e2798e5, inv_b: 1'b0,
                    exp: 128'h046681e5e0cb199a48f8d37a2806264c});
    tbl.push_back('{nm: "cols_a", din: 128'hdb135345f20a225c01010101c6c6c6c6, inv_b: 1'b0,
                    exp: 128'h8e4da1bc9fdc589d01010101c6c6c6c6});
    tbl.push_back('{nm: "cols_b", din: 128'hd4d4d4d52d26314c00000000ffffffff, inv_b: 1'b0,
                    exp: 128'hd5d5d7d64d7ebdf800000000ffffffff});
    tbl.push_back('{nm: "roundtrip_fwd", din: 128'h3e1c22c0b6fcbf768da85067f6170495, inv_b: 1'b0,
                    exp: 128'hbaa03de7a1f9b56ed5512cba5f414d23});
`ifdef MIX_COLUMNS_ITER_INV_EN
    tbl.push_back('{nm: "roundtrip_inv", din: 128'hbaa03de7a1f9b56ed5512cba5f414d23, inv_b: 1'b1,
                    exp: 128'h3e1c22c0b6fcbf768da85067f6170495});
`endif

    for (int k = 0; k < 3; k++) begin
      iv[k]   = 1'b0;
      id[k]   = '0;
      ordy[k] = 1'b1;
`ifdef MIX_COLUMNS_ITER_INV_EN
      inv_s[k] = 1'b0;
`endif
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("k%0d reset in_ready", k), ir[k], 1);
      chk($sformatf("k%0d reset out_valid", k), ov[k], 0);
      chk($sformatf("k%0d reset out_data", k), od[k], 0);
    end

    for (int k = 0; k < 3; k++) begin
      foreach (tbl[i]) run_vec(k, tbl[i].nm, tbl[i].din, tbl[i].inv_b, tbl[i].exp);
      for (int i = 0; i < 6; i++) begin
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
`ifdef MIX_COLUMNS_ITER_INV_EN
        rinv = 1'($urandom_range(0, 1));
`else
        rinv = 1'b0;
`endif
        run_vec(k, $sformatf("rand%0d", i), r, rinv, mix_ref(r, rinv));
      end
      backpressure(k);
      reset_mid_busy(k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
